i2c_target_model: RTL and testbench

//  Downstream stage of the APB-to-I2C bridge: an I2C target (slave) sitting on i2c_scl/i2c_sda.

---
 rtl/i2c_target_model_pkg.sv | 22 ++
 rtl/i2c_bus_monitor.sv | 51 +++++
 rtl/i2c_target_model.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_target_model.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_model_pkg.sv
// Shared definitions for the I2C target model: FSM state encoding,
// ACK/NACK bit levels and the default 7-bit target address.
package i2c_target_model_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_WR_PTR   = 4'd3,
    ST_WR_DATA  = 4'd4,
    ST_WR_ACK   = 4'd5,
    ST_RD_DATA  = 4'd6,
    ST_RD_ACK   = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_state_e;

  localparam logic ACK  = 1'b0;   // SDA held low in the 9th clock
  localparam logic NACK = 1'b1;   // SDA left high in the 9th clock

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: brings raw SCL/SDA into the clk domain and flags bus events.
// Ports:
//   clk, i2c_reset_n      sampling clock, async active-low reset
//   scl_in, sda_in        raw bus levels
//   scl_rise, scl_fall    one-clk pulses on synchronised SCL edges
//   start_det, stop_det   one-clk pulses: SDA fall / rise while SCL is high
//   sda_s                 synchronised SDA level (used for bit sampling)
// A pin change shows up as an event pulse two clocks later, so the FSM acts
// on it at the third clock edge.
module i2c_bus_monitor (
  input  logic clk,
  input  logic i2c_reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Reset to 1 so an idle bus never looks like an edge after reset release.
  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be high in both samples so an SCL edge never fakes a START/STOP.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_model.sv
// I2C target (slave) model with a small register file.
// Ports:
//   clk, i2c_reset_n  sampling clock (>= 8x SCL), async active-low reset
//   scl_in, sda_in    raw bus levels
//   sda_oe            1 = pull SDA low (open drain)
//   rx_data/rx_valid  last written data byte and its one-clk strobe
//   busy              set on address match, cleared on STOP/NACK/mismatch
//   mem_ptr           register pointer
//   state_dbg         current FSM state (i2c_state_e encoding)
// Handshake: there is no valid/ready pair; rx_valid is a single-clock strobe
// that qualifies rx_data with no back-pressure.
// Protocol: the first byte after an address write loads the pointer, later
// bytes store at the pointer and post-increment it; reads return mem[mem_ptr]
// and post-increment at each byte end. SDA changes only after an SCL fall.
module i2c_target_model
  import i2c_target_model_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         DATAWIDTH   = 8,
  parameter int         MEM_DEPTH   = 16,
  localparam int        PTR_W       = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 i2c_reset_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [DATAWIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic [PTR_W-1:0]     mem_ptr,
  output logic [3:0]           state_dbg
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_monitor u_mon (
    .clk        (clk),
    .i2c_reset_n(i2c_reset_n),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .sda_s      (sda_s)
  );

  i2c_state_e           state, state_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATAWIDTH-1:0] shift_reg, shift_n;
  logic [DATAWIDTH-1:0] tx_shift, tx_n;
  logic                 rw, rw_n;
  logic                 ack_bit, ack_n;
  logic                 sda_oe_n, busy_n, rx_valid_n, mem_we;
  logic [PTR_W-1:0]     ptr_n, ptr_inc;
  logic [DATAWIDTH-1:0] rx_data_n;
  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  localparam logic [3:0] BYTE_BITS = 4'(DATAWIDTH);

  assign ptr_inc   = mem_ptr + 1'b1;   // wraps naturally at MEM_DEPTH
  assign state_dbg = state;

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) state <= ST_IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    tx_n       = tx_shift;
    rw_n       = rw;
    ack_n      = ack_bit;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    ptr_n      = mem_ptr;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    mem_we     = 1'b0;
    // Bus conditions outrank any bit activity in the same clock.
    if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift_reg[DATAWIDTH-2:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == BYTE_BITS) begin
            rw_n = shift_reg[0];
            if (shift_reg[DATAWIDTH-1:1] == TARGET_ADDR) begin
              state_n  = ST_ADDR_ACK;
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (rw) begin
              // First read bit goes out in the same clock the ACK is released.
              state_n  = ST_RD_DATA;
              tx_n     = mem[mem_ptr];
              sda_oe_n = ~mem[mem_ptr][DATAWIDTH-1];
            end else begin
              state_n  = ST_WR_PTR;
              sda_oe_n = 1'b0;
            end
          end
        end
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_n   = {shift_reg[DATAWIDTH-2:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == BYTE_BITS) begin
            state_n  = ST_WR_ACK;
            sda_oe_n = 1'b1;
            if (state == ST_WR_PTR) begin
              ptr_n = shift_reg[PTR_W-1:0];
            end else begin
              mem_we     = 1'b1;
              rx_data_n  = shift_reg;
              rx_valid_n = 1'b1;
              ptr_n      = ptr_inc;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            state_n   = ST_WR_DATA;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == BYTE_BITS) begin
              state_n  = ST_RD_ACK;
              sda_oe_n = 1'b0;
            end else begin
              tx_n     = {tx_shift[DATAWIDTH-2:0], 1'b0};
              sda_oe_n = ~tx_shift[DATAWIDTH-2];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            ack_n = sda_s;
          end else if (scl_fall) begin
            ptr_n     = ptr_inc;
            bit_cnt_n = '0;
            if (ack_bit == ACK) begin
              state_n  = ST_RD_DATA;
              tx_n     = mem[ptr_inc];
              sda_oe_n = ~mem[ptr_inc][DATAWIDTH-1];
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ST_IGNORE: sda_oe_n = 1'b0;
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_shift  <= '0;
      rw        <= 1'b0;
      ack_bit   <= NACK;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      mem_ptr   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      tx_shift  <= tx_n;
      rw        <= rw_n;
      ack_bit   <= ack_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      mem_ptr   <= ptr_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      if (mem_we) mem[mem_ptr] <= shift_reg;
    end
  end

endmodule

// File: tb/tb_i2c_target_model.sv
// Testbench for i2c_target_model: a bit-banged I2C master drives the bus,
// write transactions come from a vector table, read / abort / reset corner
// cases are hand-written sequences.
module tb_i2c_target_model;
  import i2c_target_model_pkg::*;

  localparam int T = 8;   // clk cycles per SCL quarter period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i2c_reset_n;
  always #5 clk = ~clk;

  logic       scl_in, sda_m, sda_in, sda_oe, rx_valid, busy;
  logic [7:0] rx_data;
  logic [3:0] mem_ptr, state_dbg;

  // Open-drain bus: either side can pull SDA low.
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_model dut (
    .clk        (clk),
    .i2c_reset_n(i2c_reset_n),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .mem_ptr    (mem_ptr),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  logic oe_seen, busy_seen;
  logic [7:0] exp_mem [16];

  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (sda_oe)   oe_seen = 1'b1;
    if (busy)     busy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; tick(T);
    scl_in = 1'b0; tick(T);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(T);
    scl_in = 1'b1; tick(T);
    sda_m = 1'b0; tick(T);
    scl_in = 1'b0; tick(T);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(T);
    scl_in = 1'b1; tick(T);
    sda_m = 1'b1; tick(T);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(T);
    scl_in = 1'b1; tick(2 * T);
    scl_in = 1'b0; tick(T);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(T);
    scl_in = 1'b1; tick(T);
    ack = sda_in; tick(T);
    scl_in = 1'b0; tick(T);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(T);
      scl_in = 1'b1; tick(T);
      b[i] = sda_in; tick(T);
      scl_in = 1'b0; tick(T);
    end
    send_bit(ack);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] exp_acks;     // {addr, ptr, d0, d1}, 0 = ACK
    logic [3:0] exp_ptr;
    int         exp_rx;
    logic [7:0] exp_rx_data;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [3:0] acks;
    logic       a;
    logic [7:0] rb;
    logic [3:0] idx;
    int         cnt0;

    vecs[0] = '{8'hA0, 8'h03, 8'hA5, 8'h3C, 4'b0000, 4'd5, 2, 8'h3C, 1'b1};
    vecs[1] = '{8'hA2, 8'h03, 8'h77, 8'h88, 4'b1111, 4'd5, 0, 8'h3C, 1'b0};
    vecs[2] = '{8'hA0, 8'h0F, 8'h11, 8'h22, 4'b0000, 4'd1, 2, 8'h22, 1'b1};
    vecs[3] = '{8'hA0, 8'h07, 8'h5A, 8'hC3, 4'b0000, 4'd9, 2, 8'hC3, 1'b1};
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    exp_mem[3] = 8'hA5; exp_mem[4] = 8'h3C;
    exp_mem[15] = 8'h11; exp_mem[0] = 8'h22;
    exp_mem[7] = 8'h5A; exp_mem[8] = 8'hC3;

    scl_in = 1'b1; sda_m = 1'b1; i2c_reset_n = 1'b0;
    oe_seen = 1'b0; busy_seen = 1'b0;
    tick(5);
    i2c_reset_n = 1'b1;
    tick(5);

    // Reset state
    check("rst_sda_oe",   32'(sda_oe),    32'h0);
    check("rst_rx_data",  32'(rx_data),   32'h0);
    check("rst_rx_valid", 32'(rx_valid),  32'h0);
    check("rst_busy",     32'(busy),      32'h0);
    check("rst_mem_ptr",  32'(mem_ptr),   32'h0);
    check("rst_state",    32'(state_dbg), 32'(ST_IDLE));

    // Table-driven write transactions
    for (int v = 0; v < 4; v++) begin
      cnt0 = rx_cnt;
      oe_seen = 1'b0; busy_seen = 1'b0;
      i2c_start();
      write_byte(vecs[v].addr_byte, a); acks[3] = a;
      write_byte(vecs[v].ptr, a);       acks[2] = a;
      write_byte(vecs[v].d0, a);        acks[1] = a;
      write_byte(vecs[v].d1, a);        acks[0] = a;
      i2c_stop();
      tick(4);
      check($sformatf("v%0d_acks", v),      32'(acks),           32'(vecs[v].exp_acks));
      check($sformatf("v%0d_mem_ptr", v),   32'(mem_ptr),        32'(vecs[v].exp_ptr));
      check($sformatf("v%0d_rx_cnt", v),    32'(rx_cnt - cnt0),  32'(vecs[v].exp_rx));
      check($sformatf("v%0d_rx_data", v),   32'(rx_data),        32'(vecs[v].exp_rx_data));
      check($sformatf("v%0d_busy_seen", v), 32'(busy_seen),      32'(vecs[v].exp_busy));
      check($sformatf("v%0d_oe_seen", v),   32'(oe_seen),        32'(vecs[v].exp_busy));
      check($sformatf("v%0d_busy_end", v),  32'(busy),           32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      check($sformatf("mem_%0d", i), 32'(dut.mem[idx]), 32'(exp_mem[idx]));
    end

    // Pointer write, repeated START, read two bytes (ACK then NACK)
    i2c_start();
    write_byte(8'hA0, a); check("rd_addr_w_ack", 32'(a), 32'(ACK));
    write_byte(8'h03, a); check("rd_ptr_ack",    32'(a), 32'(ACK));
    i2c_rstart();
    write_byte(8'hA1, a); check("rd_addr_r_ack", 32'(a), 32'(ACK));
    read_byte(1'b0, rb);  check("rd_byte0",      32'(rb), 32'hA5);
    check("rd_busy", 32'(busy), 32'h1);
    read_byte(1'b1, rb);  check("rd_byte1",      32'(rb), 32'h3C);
    tick(2);
    check("rd_nack_state", 32'(state_dbg), 32'(ST_IGNORE));
    check("rd_nack_busy",  32'(busy),      32'h0);
    check("rd_nack_oe",    32'(sda_oe),    32'h0);
    i2c_stop();
    tick(2);
    check("rd_stop_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rd_mem_ptr",    32'(mem_ptr),   32'h5);

    // STOP in the middle of a data byte
    cnt0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h0A, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("ab_state_mid", 32'(state_dbg), 32'(ST_WR_DATA));
    sda_m = 1'b0; tick(T);
    scl_in = 1'b1; tick(T);
    sda_m = 1'b1; tick(5);
    check("ab_state",   32'(state_dbg),    32'(ST_IDLE));
    check("ab_sda_oe",  32'(sda_oe),       32'h0);
    check("ab_busy",    32'(busy),         32'h0);
    check("ab_mem_ptr", 32'(mem_ptr),      32'hA);
    check("ab_rx_cnt",  32'(rx_cnt - cnt0), 32'h0);
    check("ab_mem_10",  32'(dut.mem[4'd10]), 32'h0);

    // Async reset while the target holds the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 7);   // 0xA0
    sda_m = 1'b1; tick(T);
    check("rr_ack_drive", 32'(sda_oe), 32'h1);
    i2c_reset_n = 1'b0;
    #1;
    check("rr_sda_oe",   32'(sda_oe),         32'h0);
    check("rr_busy",     32'(busy),           32'h0);
    check("rr_mem_ptr",  32'(mem_ptr),        32'h0);
    check("rr_rx_data",  32'(rx_data),        32'h0);
    check("rr_state",    32'(state_dbg),      32'(ST_IDLE));
    check("rr_mem_3",    32'(dut.mem[4'd3]),  32'h0);
    scl_in = 1'b1; sda_m = 1'b1;
    tick(4);
    i2c_reset_n = 1'b1;
    tick(6);
    check("rr_idle_after", 32'(state_dbg), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
